// File: rtl/icache_direct_if.sv
// icache_direct_if: the fetcher- and memory-side signals of the instruction cache.
//
// Fetcher side:  br_flag (flush), if_en_i/if_pc_i (request), if_en_o/if_ins_o (reply)
// Memory side:   mem_en_o/mem_pc_o (miss request), mem_en_i/mem_ins_i (fill)
// Modports:      slave  - the cache itself
//                master - the fetcher / memory controller environment
interface icache_direct_if #(
  parameter int RAM_ADR_W = 17,
  parameter int DAT_W     = 32
);
  logic                 br_flag;
  logic                 if_en_i;
  logic [RAM_ADR_W-1:0] if_pc_i;
  logic                 if_en_o;
  logic [DAT_W-1:0]     if_ins_o;
  logic                 mem_en_o;
  logic [RAM_ADR_W-1:0] mem_pc_o;
  logic                 mem_en_i;
  logic [DAT_W-1:0]     mem_ins_i;

  modport slave (
    input  br_flag, if_en_i, if_pc_i, mem_en_i, mem_ins_i,
    output if_en_o, if_ins_o, mem_en_o, mem_pc_o
  );

  modport master (
    output br_flag, if_en_i, if_pc_i, mem_en_i, mem_ins_i,
    input  if_en_o, if_ins_o, mem_en_o, mem_pc_o
  );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache, one 32-bit word per line.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   en   - chip ready; when low, state and arrays hold and output pulses drop
//   bus  - icache_direct_if.slave: fetch request/reply, miss request/fill, branch flush
//
// A hit answers one cycle after the request. A miss issues a single-word fetch,
// waits in MISS for the fill, writes the line and answers. br_flag aborts any
// outstanding miss and drops same-cycle requests and fills.
module icache_direct #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  icache_direct_if.slave   bus
);
  localparam int RAM_ADR_W = 17;
  localparam int DAT_W     = 32;
  localparam int WORD_W    = RAM_ADR_W - 2;
  localparam int TAG_W     = RAM_ADR_W - IDX_W - 2;
  localparam int LINES     = 2 ** IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  state_t state_r, state_nxt_s;

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [DAT_W-1:0] data_r [LINES];

  logic [WORD_W-1:0]    pend_r, pend_nxt_s;
  logic                 if_en_r, if_en_nxt_s;
  logic [DAT_W-1:0]     if_ins_r, if_ins_nxt_s;
  logic                 mem_en_r, mem_en_nxt_s;
  logic [RAM_ADR_W-1:0] mem_pc_r, mem_pc_nxt_s;
  logic                 fill_we_s;

  logic [IDX_W-1:0]     rd_idx_s;
  logic [TAG_W-1:0]     rd_tag_s;
  logic                 hit_s;
  logic [RAM_ADR_W-1:0] aligned_pc_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [TAG_W-1:0]     wr_tag_s;

  assign rd_idx_s     = bus.if_pc_i[IDX_W+1:2];
  assign rd_tag_s     = bus.if_pc_i[RAM_ADR_W-1:IDX_W+2];
  assign hit_s        = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
  // Masking keeps the byte-offset bits out of the miss address.
  assign aligned_pc_s = bus.if_pc_i & {{WORD_W{1'b1}}, 2'b00};
  assign wr_idx_s     = pend_r[IDX_W-1:0];
  assign wr_tag_s     = pend_r[WORD_W-1:IDX_W];

  assign bus.if_en_o  = if_en_r;
  assign bus.if_ins_o = if_ins_r;
  assign bus.mem_en_o = mem_en_r;
  assign bus.mem_pc_o = mem_pc_r;

  // Next-state and next-output logic; flush overrides every other event.
  always_comb begin
    state_nxt_s  = state_r;
    pend_nxt_s   = pend_r;
    if_en_nxt_s  = 1'b0;
    if_ins_nxt_s = if_ins_r;
    mem_en_nxt_s = 1'b0;
    mem_pc_nxt_s = mem_pc_r;
    fill_we_s    = 1'b0;
    if (bus.br_flag) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.if_en_i) begin
            if (hit_s) begin
              if_ins_nxt_s = data_r[rd_idx_s];
              if_en_nxt_s  = 1'b1;
              state_nxt_s  = ST_IDLE;
            end else begin
              pend_nxt_s   = bus.if_pc_i[RAM_ADR_W-1:2];
              mem_pc_nxt_s = aligned_pc_s;
              mem_en_nxt_s = 1'b1;
              state_nxt_s  = ST_MISS;
            end
          end else begin
            // A stray fill in IDLE is ignored.
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MISS: begin
          // Requests are ignored here, so the fill never collides with a hit read.
          if (bus.mem_en_i) begin
            fill_we_s    = 1'b1;
            if_ins_nxt_s = bus.mem_ins_i;
            if_en_nxt_s  = 1'b1;
            state_nxt_s  = ST_IDLE;
          end else begin
            state_nxt_s = ST_MISS;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, pending address and registered outputs; en=0 freezes all but the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      pend_r   <= {WORD_W{1'b0}};
      if_en_r  <= 1'b0;
      if_ins_r <= {DAT_W{1'b0}};
      mem_en_r <= 1'b0;
      mem_pc_r <= {RAM_ADR_W{1'b0}};
    end else if (!en) begin
      if_en_r  <= 1'b0;
      mem_en_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pend_r   <= pend_nxt_s;
      if_en_r  <= if_en_nxt_s;
      if_ins_r <= if_ins_nxt_s;
      mem_en_r <= mem_en_nxt_s;
      mem_pc_r <= mem_pc_nxt_s;
    end
  end

  // Valid bits: cleared only by reset, set by a line fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (en && fill_we_s) begin
      valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (en && fill_we_s) begin
      tag_r[wr_idx_s]  <= wr_tag_s;
      data_r[wr_idx_s] <= bus.mem_ins_i;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed self-checking bench for icache_direct (IDX_W = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point,
// i.e. they show the registered result of the edge just taken.
module tb_icache_direct;
  logic clk;
  logic rst;
  logic en;
  int   n_checks;
  int   n_errors;

  icache_direct_if bus ();

  icache_direct #(.IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle fetch request; returns after the sampling edge.
  task automatic request(input logic [16:0] pc, input logic flush);
    bus.if_en_i = 1'b1;
    bus.if_pc_i = pc;
    bus.br_flag = flush;
    tick();
    bus.if_en_i = 1'b0;
    bus.br_flag = 1'b0;
  endtask

  // One-cycle fill pulse from the memory side.
  task automatic fill(input logic [31:0] ins, input logic flush);
    bus.mem_en_i  = 1'b1;
    bus.mem_ins_i = ins;
    bus.br_flag   = flush;
    tick();
    bus.mem_en_i  = 1'b0;
    bus.br_flag   = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    en            = 1'b1;
    bus.br_flag   = 1'b0;
    bus.if_en_i   = 1'b0;
    bus.if_pc_i   = 17'h00000;
    bus.mem_en_i  = 1'b0;
    bus.mem_ins_i = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_if_en",  {31'd0, bus.if_en_o},  32'd0);
    check_eq("rst_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
    check_eq("rst_ins",    bus.if_ins_o,          32'h0);
    check_eq("rst_mem_pc", {15'd0, bus.mem_pc_o}, 32'h0);

    // Cold miss: 0x00010 -> index 4, tag 0
    request(17'h00010, 1'b0);
    check_eq("cold_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    check_eq("cold_mem_pc", {15'd0, bus.mem_pc_o}, 32'h00010);
    check_eq("cold_if_en",  {31'd0, bus.if_en_o},  32'd0);
    tick();
    check_eq("cold_mem_pulse", {31'd0, bus.mem_en_o}, 32'd0);
    tick();
    tick();
    fill(32'h00A00093, 1'b0);
    check_eq("cold_fill_en",  {31'd0, bus.if_en_o}, 32'd1);
    check_eq("cold_fill_ins", bus.if_ins_o,         32'h00A00093);
    tick();
    check_eq("cold_if_pulse", {31'd0, bus.if_en_o}, 32'd0);
    check_eq("cold_ins_hold", bus.if_ins_o,         32'h00A00093);
    check_eq("cold_pc_hold",  {15'd0, bus.mem_pc_o}, 32'h00010);

    // Hit, including ignored byte-offset bits
    request(17'h00010, 1'b0);
    check_eq("hit_en",     {31'd0, bus.if_en_o},  32'd1);
    check_eq("hit_ins",    bus.if_ins_o,          32'h00A00093);
    check_eq("hit_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
    request(17'h00013, 1'b0);
    check_eq("hit_off_en", {31'd0, bus.if_en_o},  32'd1);
    check_eq("hit_off_mem",{31'd0, bus.mem_en_o}, 32'd0);

    // Conflict: 0x00050 -> index 4, tag 1
    request(17'h00050, 1'b0);
    check_eq("conf_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    check_eq("conf_mem_pc", {15'd0, bus.mem_pc_o}, 32'h00050);
    fill(32'h11111111, 1'b0);
    check_eq("conf_fill_ins", bus.if_ins_o, 32'h11111111);
    // Back-to-back request at M+1 to the just-filled line hits
    request(32'h00050, 1'b0);
    check_eq("b2b_en",     {31'd0, bus.if_en_o},  32'd1);
    check_eq("b2b_ins",    bus.if_ins_o,          32'h11111111);
    check_eq("b2b_mem_en", {31'd0, bus.mem_en_o}, 32'd0);
    request(17'h00010, 1'b0);
    check_eq("conf_remiss",    {31'd0, bus.mem_en_o}, 32'd1);
    check_eq("conf_remiss_pc", {15'd0, bus.mem_pc_o}, 32'h00010);
    fill(32'h00A00093, 1'b0);
    check_eq("conf_refill", bus.if_ins_o, 32'h00A00093);
    // 0x00052 now misses and the miss address is word-aligned
    request(17'h00052, 1'b0);
    check_eq("align_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    check_eq("align_mem_pc", {15'd0, bus.mem_pc_o}, 32'h00050);
    fill(32'h11111111, 1'b0);
    request(17'h00010, 1'b0);
    fill(32'h00A00093, 1'b0);

    // Flush during miss: 0x00100 -> index 0, no fill returned
    request(17'h00100, 1'b0);
    check_eq("fl_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    tick();
    bus.br_flag = 1'b1;
    tick();
    bus.br_flag = 1'b0;
    check_eq("fl_if_en", {31'd0, bus.if_en_o}, 32'd0);
    tick();
    check_eq("fl_if_en2", {31'd0, bus.if_en_o}, 32'd0);
    request(17'h00200, 1'b0);
    check_eq("fl_new_mem_en", {31'd0, bus.mem_en_o}, 32'd1);
    check_eq("fl_new_mem_pc", {15'd0, bus.mem_pc_o}, 32'h00200);

    // Flush coincident with fill: no answer, line stays invalid
    fill(32'hDEADBEEF, 1'b1);
    check_eq("flf_if_en", {31'd0, bus.if_en_o}, 32'd0);
    request(17'h00200, 1'b0);
    check_eq("flf_remiss", {31'd0, bus.mem_en_o}, 32'd1);
    check_eq("flf_no_hit", {31'd0, bus.if_en_o},  32'd0);

    // en gating in MISS: fill pulse while frozen is ignored
    en = 1'b0;
    tick();
    check_eq("en_mem_drop", {31'd0, bus.mem_en_o}, 32'd0);
    fill(32'h22222222, 1'b0);
    check_eq("en_fill_ign", {31'd0, bus.if_en_o}, 32'd0);
    tick();
    en = 1'b1;
    tick();
    check_eq("en_still_miss", {31'd0, bus.if_en_o}, 32'd0);
    fill(32'h33333333, 1'b0);
    check_eq("en_fill_en",  {31'd0, bus.if_en_o}, 32'd1);
    check_eq("en_fill_ins", bus.if_ins_o,         32'h33333333);
    request(17'h00200, 1'b0);
    check_eq("en_hit_ins", bus.if_ins_o,          32'h33333333);
    check_eq("en_hit_mem", {31'd0, bus.mem_en_o}, 32'd0);

    // Flush coincident with a hit request: no answer
    request(17'h00010, 1'b1);
    check_eq("flh_if_en",  {31'd0, bus.if_en_o},  32'd0);
    check_eq("flh_mem_en", {31'd0, bus.mem_en_o}, 32'd0);

    // Fill pulse in IDLE is ignored: index 0 still holds 0x00200's tag
    fill(32'h44444444, 1'b0);
    check_eq("idle_fill_en", {31'd0, bus.if_en_o}, 32'd0);
    request(17'h00100, 1'b0);
    check_eq("idle_fill_miss", {31'd0, bus.mem_en_o}, 32'd1);

    // Reset while in MISS: a later fill is ignored, all lines are invalid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rmiss_pc", {15'd0, bus.mem_pc_o}, 32'h0);
    fill(32'h55555555, 1'b0);
    check_eq("rmiss_fill_en", {31'd0, bus.if_en_o}, 32'd0);
    request(17'h00010, 1'b0);
    check_eq("rmiss_cold", {31'd0, bus.mem_en_o}, 32'd1);
    check_eq("rmiss_cold_en", {31'd0, bus.if_en_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the instruction fetcher and the memory IO controller. Hits on a fetch PC return the instruction word one cycle after the request. Misses issue a single-word fetch to the memory IO controller, fill the line and return the word. A branch flush aborts any outstanding miss.

## Interface
- IDX_W, default 4: index bits; the cache has 2^IDX_W lines of one 32-bit word each.
- clk  in  1  system clock; the block uses one clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  chip ready. When low, the block freezes.
- br_flag  in  1  branch mispredict / flush pulse.
- if_en_i  in  1  fetch request pulse from the fetcher.
- if_pc_i  in  RAM_ADR_W (17)  fetch address; bits [1:0] are ignored.
- if_en_o  out  1  one-cycle "instruction valid" pulse.
- if_ins_o  out  DAT_W (32)  instruction word; valid while if_en_o is high, held otherwise.
- mem_en_o  out  1  one-cycle miss request pulse to the memory IO controller.
- mem_pc_o  out  RAM_ADR_W  miss address, word-aligned (bits [1:0] = 0); held until the next miss.
- mem_en_i  in  1  one-cycle fill-done pulse from the memory IO controller.
- mem_ins_i  in  DAT_W  fill word; valid while mem_en_i is high.

## Operation
- Storage per line: valid bit, tag, 32-bit data.
  - index = pc[IDX_W+1:2]
  - tag = pc[RAM_ADR_W-1:IDX_W+2]
- Reset: all valid bits cleared; state IDLE; if_en_o=0, mem_en_o=0, if_ins_o=0, mem_pc_o=0; pending address register cleared.
- en=0:
  - State, valid, tag and data arrays, and pending address hold.
  - if_en_o and mem_en_o are driven 0 on the next edge.
- Default every enabled cycle: if_en_o<=0 and mem_en_o<=0, so both outputs are pulses.
- FSM states: IDLE and MISS.
  - IDLE, if_en_i=1, hit (valid and tag match): if_ins_o<=data, if_en_o<=1; stay in IDLE.
  - IDLE, if_en_i=1, miss:
    - latch the pending PC;
    - mem_pc_o<={pc[RAM_ADR_W-1:2],2'b00}, mem_en_o<=1;
    - go to MISS.
  - MISS, mem_en_i=1:
    - write the line at the pending index: valid=1, tag, data=mem_ins_i;
    - if_ins_o<=mem_ins_i, if_en_o<=1;
    - go to IDLE.
  - MISS, if_en_i=1: the request is ignored. The fetcher must not issue while a request is outstanding.
  - IDLE, mem_en_i=1: ignored; no write to the arrays.
- br_flag=1 (enabled cycle) has priority over everything:
  - state<=IDLE; if_en_o<=0; mem_en_o<=0;
  - any if_en_i in the same cycle is dropped;
  - any mem_en_i in the same cycle is ignored, with no line fill;
  - valid bits are untouched.
- No write port and no invalidation other than rst. Instruction memory is treated as immutable.

## Timing
- Hit latency: if_en_i at edge T leads to if_en_o high in cycle T+1.
- Miss: if_en_i at T leads to mem_en_o high in cycle T+1. When mem_en_i is sampled at edge M, if_en_o is high in cycle M+1 and the line is readable by a request at M+1.
- A back-to-back request to the just-filled line, issued at M+1, hits, and if_en_o is high at M+2.
- Array read is combinational on if_pc_i. Array write happens at the mem_en_i edge.
- A hit-path read and a fill write never occur in the same cycle, because requests are ignored in MISS.
- A flush at the same edge as a hit request means no if_en_o is produced.
- mem_en_o is never high for two consecutive cycles. At most one miss is outstanding.
- Reset in MISS: the block returns to IDLE. A later mem_en_i is ignored because the block is in IDLE.

## Test plan
- Cold miss:
  - Stimulus: after reset, request pc=0x00010; memory returns 0x00A00093 four cycles after mem_en_o.
  - Required: mem_en_o=1 with mem_pc_o=0x00010 one cycle after the request; if_en_o=1 with if_ins_o=0x00A00093 one cycle after mem_en_i.
- Hit:
  - Stimulus: re-request 0x00010.
  - Required: if_en_o=1 with 0x00A00093 the next cycle; mem_en_o stays 0.
- Conflict:
  - Stimulus: IDX_W=4; fill 0x00010, then request 0x00050 (same index, different tag).
  - Required: the request misses and mem_pc_o=0x00050. After the fill, 0x00010 misses again.
- Flush during miss:
  - Stimulus: request 0x00100; assert br_flag two cycles later; the memory controller returns no fill.
  - Required: no if_en_o; state returns to IDLE; a new request to 0x00200 issues mem_en_o.
- Flush coincident with fill:
  - Stimulus: br_flag and mem_en_i in the same cycle.
  - Required: no if_en_o; the line stays invalid, so a re-request misses.
- en gating:
  - Stimulus: hold en=0 for three cycles in MISS, with mem_en_i asserted for one cycle in the middle.
  - Required: the fill pulse is ignored and the block stays in MISS. A fill with en=1 then completes normally.
